// File: rtl/alu_arbiter_if.sv
// Bus bundle between two ALU requesters, the arbiter and one shared ALU.
// The slave modport is the arbiter's view; the master modport is the view
// of the surrounding system (requesters, response consumers, shared ALU).
interface alu_arbiter_if;
    // Requester 0/1 operation channel
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_sel;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_sel;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    // Requester 0/1 response channel
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_result;
    logic        rsp0_err;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_result;
    logic        rsp1_err;

    // Shared ALU connection
    logic [3:0]  alu_sel;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_result;

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b,
        input  req1_valid, req1_sel, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_err,
        output rsp1_valid, rsp1_result, rsp1_err,
        input  rsp0_ready, rsp1_ready,
        output alu_sel, alu_a, alu_b,
        input  alu_result
    );

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b,
        output req1_valid, req1_sel, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_err,
        input  rsp1_valid, rsp1_result, rsp1_err,
        output rsp0_ready, rsp1_ready,
        input  alu_sel, alu_a, alu_b,
        output alu_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation walks IDLE -> EXEC -> RESP; the ALU is only ever fed from
// the captured operand registers, and op codes 12..15 return 0 with err set.
module alu_arbiter (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_ptr;
    logic        r_owner;
    logic        r_err;
    logic [3:0]  r_sel;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_result;

    logic        w_grant0;
    logic        w_grant1;
    logic        w_rsp_done;
    logic        w_rsp_v0;
    logic        w_rsp_v1;

    // Op codes above the defined set (12..15) are rejected by the arbiter.
    function automatic logic is_illegal_op(input logic [3:0] sel);
        return (sel >= 4'd12);
    endfunction

    // Grant at most one requester while idle; a lone requester wins regardless of the pointer.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if ((r_state == ST_IDLE) && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_grant0 = ~r_ptr;
                w_grant1 = r_ptr;
            end else begin
                w_grant0 = bus.req0_valid;
                w_grant1 = bus.req1_valid;
            end
        end else begin
            w_grant0 = 1'b0;
            w_grant1 = 1'b0;
        end
    end

    assign w_rsp_done = (r_state == ST_RESP) &&
                        (r_owner ? bus.rsp1_ready : bus.rsp0_ready);

    // Next-state decode: one cycle of EXEC, RESP held until the owner consumes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: begin
                if (w_rsp_done) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture on grant, result capture in EXEC, pointer handover on response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_err    <= 1'b0;
            r_sel    <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_result <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant1) begin
                        r_owner <= 1'b1;
                        r_sel   <= bus.req1_sel;
                        r_a     <= bus.req1_a;
                        r_b     <= bus.req1_b;
                    end else if (w_grant0) begin
                        r_owner <= 1'b0;
                        r_sel   <= bus.req0_sel;
                        r_a     <= bus.req0_a;
                        r_b     <= bus.req0_b;
                    end
                end
                ST_EXEC: begin
                    if (is_illegal_op(r_sel)) begin
                        r_result <= 32'd0;
                        r_err    <= 1'b1;
                    end else begin
                        r_result <= bus.alu_result;
                        r_err    <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (w_rsp_done) begin
                        r_ptr <= ~r_owner;
                    end
                end
                default: begin
                    r_ptr <= 1'b0;
                end
            endcase
        end
    end

    assign w_rsp_v0 = (r_state == ST_RESP) && !r_owner;
    assign w_rsp_v1 = (r_state == ST_RESP) &&  r_owner;

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.rsp0_valid  = w_rsp_v0;
    assign bus.rsp1_valid  = w_rsp_v1;
    assign bus.rsp0_result = w_rsp_v0 ? r_result : 32'd0;
    assign bus.rsp1_result = w_rsp_v1 ? r_result : 32'd0;
    assign bus.rsp0_err    = w_rsp_v0 ? r_err : 1'b0;
    assign bus.rsp1_err    = w_rsp_v1 ? r_err : 1'b0;
    assign bus.alu_sel     = r_sel;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requester tasks push the expected
// response when their request is accepted, and a negedge monitor compares
// grants, response timing and response data against a transaction model.
module tb_alu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rand_rdy = 1'b0;

    // Model state: one outstanding op at most, round-robin pointer
    bit m_busy  = 1'b0;
    bit m_ptr   = 1'b0;
    bit m_owner = 1'b0;
    int m_age   = 0;

    // RISC-V style ALU semantics, written straight from the op list
    function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return $unsigned($signed(a) >>> b[4:0]);
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            4'd10:   return b << 12;
            4'd11:   return a + (b << 12);
            default: return 32'd0;
        endcase
    endfunction

    // Shared ALU stand-in; illegal codes give junk that must never reach a response
    assign bus.alu_result = (bus.alu_sel >= 4'd12) ? 32'hDEAD_BEEF : ref_alu(bus.alu_sel, bus.alu_a, bus.alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Raise a request (called just after a posedge) and wait for acceptance
    task automatic do_req(input bit n, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, output int waited);
        logic rdy;
        if (n) begin
            bus.req1_valid = 1'b1; bus.req1_sel = sel; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_sel = sel; bus.req0_a = a; bus.req0_b = b;
        end
        waited = 0;
        @(negedge clk);
        rdy = n ? bus.req1_ready : bus.req0_ready;
        while (!rdy && waited < 200) begin
            waited++;
            @(negedge clk);
            rdy = n ? bus.req1_ready : bus.req0_ready;
        end
        if (rdy) begin
            @(posedge clk);
            sb.push_back('{owner: n, res: er, err: ee});
        end else begin
            n_checks++;
            $display("FAIL req%0d_accept_timeout: got no ready expected ready within 200 cycles", n);
        end
        #1;
        if (n) bus.req1_valid = 1'b0;
        else   bus.req0_valid = 1'b0;
    endtask

    task automatic rand_stream(input bit n, input int count);
        int w;
        logic [3:0] s;
        logic [31:0] a, b;
        logic ee;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            ee = (s >= 4'd12);
            do_req(n, s, a, b, ee ? 32'd0 : ref_alu(s, a, b), ee, w);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((m_busy || sb.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_idle", 32'(m_busy), 32'd0);
    endtask

    // Monitor: expected grant, response timing and data, reset output values
    always @(negedge clk) begin
        logic e_r0, e_r1, e_v0, e_v1;
        exp_t e;
        if (rst) begin
            chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
            chk("rst_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
            chk("rst_rsp0_result", bus.rsp0_result, 32'd0);
            chk("rst_rsp1_result", bus.rsp1_result, 32'd0);
            chk("rst_rsp_err", {30'd0, bus.rsp1_err, bus.rsp0_err}, 32'd0);
            chk("rst_alu_sel", 32'(bus.alu_sel), 32'd0);
            chk("rst_alu_a", bus.alu_a, 32'd0);
            chk("rst_alu_b", bus.alu_b, 32'd0);
            m_busy = 1'b0; m_ptr = 1'b0; m_age = 0;
            sb.delete();
        end else begin
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (!m_busy) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    e_r0 = !m_ptr; e_r1 = m_ptr;
                end else begin
                    e_r0 = bus.req0_valid; e_r1 = bus.req1_valid;
                end
            end
            chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));
            if (e_r0 || e_r1) begin
                m_busy = 1'b1; m_owner = e_r1; m_age = 0;
            end else if (m_busy) begin
                m_age++;
            end
            e_v0 = m_busy && (m_age >= 2) && !m_owner;
            e_v1 = m_busy && (m_age >= 2) &&  m_owner;
            chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(e_v0));
            chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(e_v1));
            if (e_v0 || e_v1) begin
                if (sb.size() == 0) begin
                    chk("sb_entry_present", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb[0];
                    chk("rsp_owner", 32'(e.owner), 32'(m_owner));
                    if (m_owner) begin
                        chk("rsp1_result", bus.rsp1_result, e.res);
                        chk("rsp1_err", 32'(bus.rsp1_err), 32'(e.err));
                        chk("rsp0_result_quiet", bus.rsp0_result, 32'd0);
                    end else begin
                        chk("rsp0_result", bus.rsp0_result, e.res);
                        chk("rsp0_err", 32'(bus.rsp0_err), 32'(e.err));
                        chk("rsp1_result_quiet", bus.rsp1_result, 32'd0);
                    end
                    if (m_owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                        void'(sb.pop_front());
                        m_busy = 1'b0;
                        m_ptr  = !m_owner;
                    end
                end
            end else begin
                chk("rsp_result_quiet", bus.rsp0_result | bus.rsp1_result, 32'd0);
                chk("rsp_err_quiet", {30'd0, bus.rsp1_err, bus.rsp0_err}, 32'd0);
            end
        end
    end

    // Random response backpressure while the random phase runs
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                bus.rsp0_ready = ($urandom_range(0, 3) != 0);
                bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Directed scenarios followed by a random two-requester stream
    initial begin
        int w;
        bus.req0_valid = 1'b0; bus.req0_sel = 4'd0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
        bus.req1_valid = 1'b0; bus.req1_sel = 4'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single op: 5 + 7
        do_req(1'b0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, w);
        wait_drain();

        // Contention from reset: grants must go 0,1,0,1
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        fork
            begin
                int w0;
                do_req(1'b0, 4'd0, 32'd100, 32'd23, 32'd123, 1'b0, w0);
                do_req(1'b0, 4'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, w0);
            end
            begin
                int w1;
                do_req(1'b1, 4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, w1);
                do_req(1'b1, 4'd6, 32'h8000_0000, 32'd31, 32'd1, 1'b0, w1);
            end
        join
        wait_drain();

        // Backpressure on requester 1 while requester 0 waits
        bus.rsp1_ready = 1'b0;
        do_req(1'b1, 4'd2, 32'hF0F0_0000, 32'h0F0F_1234, 32'hFFFF_1234, 1'b0, w);
        fork
            begin
                int w2;
                do_req(1'b0, 4'd3, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, w2);
            end
        join_none
        repeat (6) @(posedge clk);
        #1 bus.rsp1_ready = 1'b1;
        wait fork;
        wait_drain();

        // Illegal op, then lui
        do_req(1'b0, 4'd13, 32'd1, 32'd2, 32'd0, 1'b1, w);
        do_req(1'b0, 4'd10, 32'd0, 32'd1, 32'h0000_1000, 1'b0, w);
        wait_drain();

        // Signed/unsigned compares and shifts
        do_req(1'b0, 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, w);
        do_req(1'b0, 4'd9, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, w);
        do_req(1'b0, 4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, w);
        do_req(1'b0, 4'd5, 32'd1, 32'd31, 32'h8000_0000, 1'b0, w);
        do_req(1'b1, 4'd11, 32'h0000_0100, 32'd2, 32'h0000_2100, 1'b0, w);
        wait_drain();

        // Reset while the op is in EXEC: no response afterwards
        do_req(1'b0, 4'd0, 32'd1, 32'd1, 32'd2, 1'b0, w);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        do_req(1'b1, 4'd0, 32'd10, 32'd20, 32'd30, 1'b0, w);
        chk("post_rst_req1_first_cycle", 32'(w), 32'd0);
        wait_drain();

        // Random contention with random backpressure
        rand_rdy = 1'b1;
        fork
            rand_stream(1'b0, 30);
            rand_stream(1'b1, 30);
        join
        rand_rdy = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        wait_drain();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
